// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave.
//   spi_slv_state_t : frame FSM states (IDLE, CMD, DATA, DONE)
//   SPI_CMD_WIDTH   : command byte length in bits
//   SPI_SYNC_STAGES : flip-flops per input synchronizer
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } spi_slv_state_t;

    localparam int SPI_CMD_WIDTH   = 8;
    localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-stage synchronizer for one asynchronous input,
// followed by a single edge-detect stage.
//   clk   : system clock
//   rst   : synchronous active-low reset (chain loads RST_VAL)
//   d     : asynchronous input
//   level : synchronized level
//   rise  : 1-cycle pulse on a synchronized 0->1 transition
//   fall  : 1-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx: mode-0 SPI slave oversampled by the system clock.
// Receives an 8-bit command then DATA_BYTE_WIDTH data bytes on MOSI and
// shifts a preloaded word out on MISO during the data phase.
//   i_clk, i_rst          : system clock, synchronous active-low reset
//   i_sclk, i_cs, i_mosi  : asynchronous SPI pins from the master
//   o_miso, o_miso_oe     : slave data out and its output enable
//   i_tx_data, i_load_en  : word for the next frame, captured while idle
//   o_busy                : frame in progress
//   o_cmd, o_cmd_valid    : last command byte and its update pulse
//   o_rx_data, o_rx_valid : last data word and its update pulse
//   o_frame_err           : pulse when CS rises before the frame completes
module spi_slave_rx_tx
    import spi_pkg::*;
#(
    parameter int DATA_BYTE_WIDTH = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_sclk,
    input  logic                         i_cs,
    input  logic                         i_mosi,
    output logic                         o_miso,
    output logic                         o_miso_oe,
    input  logic [8*DATA_BYTE_WIDTH-1:0] i_tx_data,
    input  logic                         i_load_en,
    output logic                         o_busy,
    output logic [SPI_CMD_WIDTH-1:0]     o_cmd,
    output logic                         o_cmd_valid,
    output logic [8*DATA_BYTE_WIDTH-1:0] o_rx_data,
    output logic                         o_rx_valid,
    output logic                         o_frame_err
);

    localparam int DW     = 8 * DATA_BYTE_WIDTH;
    localparam int FRAME  = SPI_CMD_WIDTH + DW;
    localparam int CW     = $clog2(FRAME + 1);
    localparam int SETTLE = SPI_SYNC_STAGES + 1;
    localparam int SW     = $clog2(SETTLE + 1);

    localparam logic [CW-1:0] CNT_CMD_LAST  = CW'(SPI_CMD_WIDTH - 1);
    localparam logic [CW-1:0] CNT_CMD_DONE  = CW'(SPI_CMD_WIDTH);
    localparam logic [CW-1:0] CNT_DATA_LAST = CW'(FRAME - 1);
    localparam logic [SW-1:0] SETTLE_END    = SW'(SETTLE);

    logic sclk_rise, sclk_fall, sclk_level;
    logic cs_rise, cs_fall, cs_level;
    logic mosi, mosi_unused_rise, mosi_unused_fall;

    spi_sync_edge #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(i_clk), .rst(i_rst), .d(i_sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(i_clk), .rst(i_rst), .d(i_cs),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(i_clk), .rst(i_rst), .d(i_mosi),
        .level(mosi), .rise(mosi_unused_rise), .fall(mosi_unused_fall)
    );

    spi_slv_state_t     state, state_n;
    logic [CW-1:0]      bit_cnt, bit_cnt_n;
    logic [DW-2:0]      rx_shift, rx_shift_n;
    logic [DW-1:0]      rx_word;
    logic [DW-1:0]      tx_shift, tx_shift_n;
    logic [DW-1:0]      tx_hold, tx_hold_n;
    logic               miso_n, oe_n;
    logic [SPI_CMD_WIDTH-1:0] cmd_n;
    logic [DW-1:0]      rx_data_n;
    logic               cmd_valid_n, rx_valid_n, frame_err_n;
    // The CS synchronizer resets to "high", so a CS already low at reset
    // release looks like a falling edge. Frames are only accepted once CS
    // has been seen high after the synchronizer chain has flushed.
    logic [SW-1:0]      settle, settle_n;
    logic               armed, armed_n;
    logic               sclk_unused_level;

    assign sclk_unused_level = sclk_level;
    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_hold     <= '0;
            o_miso      <= 1'b0;
            o_miso_oe   <= 1'b0;
            o_cmd       <= '0;
            o_cmd_valid <= 1'b0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            settle      <= '0;
            armed       <= 1'b0;
        end else begin
            bit_cnt     <= bit_cnt_n;
            rx_shift    <= rx_shift_n;
            tx_shift    <= tx_shift_n;
            tx_hold     <= tx_hold_n;
            o_miso      <= miso_n;
            o_miso_oe   <= oe_n;
            o_cmd       <= cmd_n;
            o_cmd_valid <= cmd_valid_n;
            o_rx_data   <= rx_data_n;
            o_rx_valid  <= rx_valid_n;
            o_frame_err <= frame_err_n;
            settle      <= settle_n;
            armed       <= armed_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        rx_shift_n  = rx_shift;
        tx_shift_n  = tx_shift;
        tx_hold_n   = tx_hold;
        miso_n      = o_miso;
        oe_n        = o_miso_oe;
        cmd_n       = o_cmd;
        rx_data_n   = o_rx_data;
        cmd_valid_n = 1'b0;
        rx_valid_n  = 1'b0;
        frame_err_n = 1'b0;
        rx_word     = {rx_shift, mosi};
        settle_n    = (settle == SETTLE_END) ? settle : settle + 1'b1;
        armed_n     = armed | ((settle == SETTLE_END) & cs_level);

        unique case (state)
            IDLE: begin
                if (i_load_en) tx_hold_n = i_tx_data;
                if (cs_fall && armed) begin
                    state_n    = CMD;
                    bit_cnt_n  = '0;
                    tx_shift_n = tx_hold;
                end
            end
            CMD: begin
                if (sclk_rise) begin
                    rx_shift_n = rx_word[DW-2:0];
                    bit_cnt_n  = bit_cnt + 1'b1;
                    if (bit_cnt == CNT_CMD_LAST) begin
                        cmd_n       = rx_word[SPI_CMD_WIDTH-1:0];
                        cmd_valid_n = 1'b1;
                        miso_n      = tx_shift[DW-1];
                        oe_n        = 1'b1;
                        state_n     = DATA;
                    end
                end
            end
            DATA: begin
                // The falling edge right after the last command bit must not
                // shift: the MSB was only just presented and the master
                // samples it on the following rising edge.
                if (sclk_fall && bit_cnt != CNT_CMD_DONE) begin
                    tx_shift_n = {tx_shift[DW-2:0], 1'b0};
                    miso_n     = tx_shift[DW-2];
                end
                if (sclk_rise) begin
                    rx_shift_n = rx_word[DW-2:0];
                    bit_cnt_n  = bit_cnt + 1'b1;
                    if (bit_cnt == CNT_DATA_LAST) begin
                        rx_data_n  = rx_word;
                        rx_valid_n = 1'b1;
                        state_n    = DONE;
                    end
                end
            end
            DONE: begin
            end
        endcase

        // CS release ends any frame; completion in the same cycle wins.
        if (state != IDLE && cs_rise) begin
            frame_err_n = (state == CMD || state == DATA) && !rx_valid_n;
            state_n     = IDLE;
            oe_n        = 1'b0;
            miso_n      = 1'b0;
        end
    end

endmodule

// File: doc/spi_slave_rx_tx.md
# spi_slave_rx_tx

Mode-0 (CPOL=0, CPHA=0) SPI responder clocked by the system clock. It oversamples the master's sCLK, CS and MOSI, and captures an 8-bit command byte followed by DATA_BYTE_WIDTH data bytes from MOSI. During the data phase it shifts a preloaded word out on MISO. It is the slave end of the SPI link that `spi_interface` monitors, and it produces the `slave_rx_data`, `slave_tx_data`, `load_en` and `rx_reg` behaviour that those checks expect.

## Interface
Parameters:
- DATA_BYTE_WIDTH, 1: data bytes per frame after the command byte; frame length = 8 + 8*DATA_BYTE_WIDTH bits.

Ports (one clock, `i_clk`; reset `i_rst` is synchronous and active-low):
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-low reset
- i_sclk  in  1  SPI clock from master, asynchronous
- i_cs  in  1  chip select, active-low, asynchronous
- i_mosi  in  1  master-out data, asynchronous
- o_miso  out  1  slave-out data
- o_miso_oe  out  1  MISO output enable; 1 only in the data phase
- i_tx_data  in  8*DATA_BYTE_WIDTH  word to transmit next frame
- i_load_en  in  1  capture i_tx_data into the hold register; honoured only when o_busy=0
- o_busy  out  1  frame in progress
- o_cmd  out  8  last received command byte
- o_cmd_valid  out  1  1-cycle pulse when o_cmd updates
- o_rx_data  out  8*DATA_BYTE_WIDTH  last received data word
- o_rx_valid  out  1  1-cycle pulse when o_rx_data updates
- o_frame_err  out  1  1-cycle pulse when CS deasserts before the frame is complete

## Operation
- Inputs pass through 2-FF synchronizers, then one edge-detect stage.
  - Synchronizer reset values: sclk=0, cs=1, mosi=0.
- FSM states: IDLE, CMD, DATA, DONE.
- IDLE: o_busy=0, o_miso_oe=0.
  - i_load_en=1 → tx_hold <= i_tx_data.
  - CS falling edge → CMD; bit_cnt <= 0; tx_shift <= tx_hold.
- Every detected sCLK rising edge in CMD or DATA:
  - rx_shift <= {rx_shift, mosi_sync}.
  - bit_cnt++.
- CMD, on the 8th rising edge:
  - o_cmd <= received byte; o_cmd_valid pulses.
  - o_miso <= tx_shift MSB; o_miso_oe <= 1; go to DATA.
- DATA:
  - Each sCLK falling edge: tx_shift shifts left; o_miso <= new MSB.
  - On rising edge 8+8*DATA_BYTE_WIDTH: o_rx_data <= data bits, MSB first; o_rx_valid pulses; go to DONE.
- DONE: further sCLK edges are ignored; o_miso holds its last value.
- CS rising edge in any non-IDLE state:
  - Go to IDLE; o_miso_oe <= 0; o_miso <= 0.
  - If the state was CMD or DATA, o_frame_err pulses.
  - Partial data is discarded; o_rx_data is unchanged.
- tx_hold is not consumed by a frame. Without a new i_load_en, the same word is resent next frame.

## Timing
- Pin edge to internal event: 3 i_clk cycles (2 sync + 1 edge detect). Outputs register one cycle later.
- Constraints: sCLK half-period ≥ 4 i_clk cycles; CS setup and hold around the first and last sCLK edge ≥ 4 i_clk cycles.
- MISO data changes ≤ 4 i_clk cycles after the detected falling edge. The master samples on the next rising edge.
- Pulses o_cmd_valid, o_rx_valid and o_frame_err are exactly 1 cycle wide.
- Simultaneous events:
  - CS rise detected in the same cycle as the final sCLK rise: completion wins; o_rx_valid pulses, o_frame_err does not.
  - i_load_en while o_busy=1: ignored.
- Reset, including mid-frame:
  - All outputs 0, FSM IDLE, counters and shift registers 0; no pulses.
  - If CS is already low at reset release, the block waits for CS high followed by a new falling edge.

## Structure
- Package `spi_pkg`:
  - state enum `spi_slv_state_t` (IDLE, CMD, DATA, DONE);
  - `SPI_CMD_WIDTH=8`;
  - `SPI_SYNC_STAGES=2`.
- Sub-module `spi_sync_edge`: parameterised synchronizer with rise/fall outputs, instantiated for sclk, cs and mosi. The mosi instance uses only its level output.
- bit_cnt width: $clog2(8+8*DATA_BYTE_WIDTH+1).

## Test plan
- Reset, then load, then one frame. DATA_BYTE_WIDTH=1; i_load_en with i_tx_data=8'hA5; master sends cmd 8'h3C, data 8'h96.
  - Response: o_cmd=8'h3C with one o_cmd_valid pulse; o_rx_data=8'h96 with one o_rx_valid pulse; master reads 8'hA5 on MISO.
  - o_miso_oe=0 during all 8 command bits.
- DATA_BYTE_WIDTH=2; tx 16'hBEEF; master sends cmd 8'h01, data 16'h1234.
  - Response: o_rx_data=16'h1234; MISO reads 16'hBEEF, MSB first.
- CS rise after 12 of 16 bits.
  - Response: o_frame_err pulses once; o_rx_data keeps its previous value; FSM IDLE.
  - The next full frame completes correctly.
- i_load_en=1 with 8'hFF during a frame carrying tx 8'h5A.
  - Response: MISO sends 8'h5A; the following frame resends 8'h5A.
- i_rst=0 asserted mid-data-phase with CS held low.
  - Response: all outputs 0; no frame starts until CS goes high then low again.
  - Extra sCLK edges after bit 16, before CS rise: ignored, no error.
